hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow copy of the destination-register state of the DEC/EX, EX/MEM and MEM/WB pipeline registers and drives those fields to the forwarding logic. It also detects load-use and HI/LO multiply/divide hazards, generates PC/IF-DEC stalls and bubble insertion, and squashes the wrong-path instruction on a taken branch. It sits beside the decode stage and consumes the decoded fields of the instruction currently in decode.

## Interface
- MULDIV_CYCLES, 32: busy cycles of the HI/LO unit after a mult/div is issued (1..63).

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- dec_valid  in  1  decode holds a real instruction
- dec_rs, dec_rt  in  5 each  source register numbers in decode
- dec_uses_rs, dec_uses_rt  in  1 each  the instruction reads rs / rt
- dec_rd  in  5  final destination register (after RegDst mux)
- dec_regwrite  in  1  the instruction writes the register file
- dec_memread  in  1  the instruction is a load
- dec_muldiv  in  1  the instruction is mult/multu/div/divu
- dec_mfhilo  in  1  the instruction is mfhi/mflo
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- stall_f  out  1  hold PC and the IF/DEC register
- flush_if_dec  out  1  clear the IF/DEC register
- flush_dec_ex  out  1  load a bubble into DEC/EX
- dec_ex_rd, ex_mem_rd, mem_wb_rd  out  5 each  tracked destinations
- dec_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite  out  1 each  tracked write enables
- dec_ex_memread  out  1  the DEC/EX instruction is a load
- muldiv_busy  out  1  HI/LO result not yet valid

## Operation
- Shadow pipeline: each clock, mem_wb ← ex_mem and ex_mem ← dec_ex. dec_ex ← the decode fields, or all-zero when `bubble = flush_dec_ex | ~dec_valid`.
- A stored regwrite is forced to 0 when rd == 0, so all tracked regwrite outputs are 0 for $zero.
- load_use = dec_ex_memread & dec_ex_regwrite & dec_valid & ((dec_uses_rs & dec_rs == dec_ex_rd) | (dec_uses_rt & dec_rt == dec_ex_rd)).
- The 6-bit muldiv counter has these rules:
  - It loads MULDIV_CYCLES when an instruction with dec_muldiv is accepted (dec_valid & ~stall_f & ~ex_branch_taken).
  - Otherwise it decrements while nonzero.
  - muldiv_busy = (count != 0).
- hilo_stall = dec_valid & muldiv_busy & (dec_mfhilo | dec_muldiv).
- Outputs are combinational from the current state and inputs:
  - stall_f = (load_use | hilo_stall) & ~ex_branch_taken
  - flush_if_dec = ex_branch_taken
  - flush_dec_ex = load_use | hilo_stall | ex_branch_taken
- Priority: a taken branch beats any stall. The decode instruction is squashed, and a mult/div in decode does not load the counter. A mult/div already counting is older and continues to count.
- Reset: all tracked rd = 0, all regwrite/memread = 0, count = 0, so muldiv_busy = 0, stall_f = 0 and both flushes = 0 while reset_n = 0 and ex_branch_taken = 0. Reset asserted mid-operation clears the counter and shadow state on the next edge, with no residual stall.

## Timing
- Tracked outputs are registered and change 1 cycle after the decode fields are presented.
- Load-use stall lasts exactly 1 cycle: the bubble in dec_ex clears the condition on the next edge.
- A mult/div accepted at edge E gives muldiv_busy = 1 for cycles E+1 .. E+MULDIV_CYCLES. A dependent mfhi in decode stalls through those cycles and is accepted in the first cycle where busy = 0.
- Back-to-back mult/div: the second one stalls until busy = 0, then reloads the counter.
- Load-use and hilo_stall may be simultaneous; both produce the same single stall/bubble action.
- No cycle may have stall_f = 1 with flush_if_dec = 1.

## Test plan
- Load-use: lw $5 enters dec_ex, decode has add using rs = 5 → stall_f = 1 and flush_dec_ex = 1 for 1 cycle, then dec_ex_regwrite = 0 (bubble) and ex_mem_rd = 5.
- Load to $0: lw $0 followed by use of $0 → no stall; dec_ex_regwrite = 0.
- Mult then mflo (MULDIV_CYCLES = 4): mult accepted at cycle 0 → busy cycles 1–4, mflo stalled 4 cycles and accepted at cycle 5.
- Branch taken while load_use = 1 → stall_f = 0, flush_if_dec = 1, flush_dec_ex = 1. A mult in decode during the taken branch leaves busy = 0.
- Shadow pipeline: issue writes to rd = 3, 7, 9 on consecutive cycles → on cycle 3, mem_wb_rd = 3, ex_mem_rd = 7, dec_ex_rd = 9, all regwrite = 1.
- Reset mid-count (count = 10) with reset_n = 0 for 1 edge → busy = 0, all tracked fields = 0, stall_f = 0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: shadow tracking of pipeline destination registers, load-use
// and HI/LO hazard detection, stall/bubble generation, taken-branch squash.
module hazard_unit #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs,
  input  logic [4:0] dec_rt,
  input  logic       dec_uses_rs,
  input  logic       dec_uses_rt,
  input  logic [4:0] dec_rd,
  input  logic       dec_regwrite,
  input  logic       dec_memread,
  input  logic       dec_muldiv,
  input  logic       dec_mfhilo,
  input  logic       ex_branch_taken,
  output logic       stall_f,
  output logic       flush_if_dec,
  output logic       flush_dec_ex,
  output logic [4:0] dec_ex_rd,
  output logic [4:0] ex_mem_rd,
  output logic [4:0] mem_wb_rd,
  output logic       dec_ex_regwrite,
  output logic       ex_mem_regwrite,
  output logic       mem_wb_regwrite,
  output logic       dec_ex_memread,
  output logic       muldiv_busy
);

  localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYCLES);

  logic [4:0] dec_ex_rd_q, ex_mem_rd_q, mem_wb_rd_q;
  logic       dec_ex_rw_q, ex_mem_rw_q, mem_wb_rw_q;
  logic       dec_ex_mr_q;
  logic [5:0] cnt_q;

  logic [4:0] dec_ex_rd_d;
  logic       dec_ex_rw_d, dec_ex_mr_d;
  logic [5:0] cnt_d;
  logic       load_use, hilo_stall, bubble, accept;

  // Hazard detection, control outputs and next-state of the shadow pipeline
  always_comb begin
    load_use = dec_ex_mr_q & dec_ex_rw_q & dec_valid &
               ((dec_uses_rs & (dec_rs == dec_ex_rd_q)) |
                (dec_uses_rt & (dec_rt == dec_ex_rd_q)));
    muldiv_busy  = (cnt_q != '0);
    hilo_stall   = dec_valid & muldiv_busy & (dec_mfhilo | dec_muldiv);
    // A taken branch squashes decode, so holding it would be pointless
    stall_f      = (load_use | hilo_stall) & ~ex_branch_taken;
    flush_if_dec = ex_branch_taken;
    flush_dec_ex = load_use | hilo_stall | ex_branch_taken;
    bubble       = flush_dec_ex | ~dec_valid;
    accept       = dec_valid & ~stall_f & ~ex_branch_taken;

    dec_ex_rd_d  = bubble ? '0 : dec_rd;
    dec_ex_rw_d  = ~bubble & dec_regwrite & (dec_rd != '0);
    dec_ex_mr_d  = ~bubble & dec_memread;

    cnt_d = cnt_q;
    if (accept && dec_muldiv) begin
      cnt_d = MD_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 6'd1;
    end

    dec_ex_rd       = dec_ex_rd_q;
    ex_mem_rd       = ex_mem_rd_q;
    mem_wb_rd       = mem_wb_rd_q;
    dec_ex_regwrite = dec_ex_rw_q;
    ex_mem_regwrite = ex_mem_rw_q;
    mem_wb_regwrite = mem_wb_rw_q;
    dec_ex_memread  = dec_ex_mr_q;
  end

  // Shadow pipeline advance and HI/LO busy counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_ex_rd_q <= '0;
      ex_mem_rd_q <= '0;
      mem_wb_rd_q <= '0;
      dec_ex_rw_q <= 1'b0;
      ex_mem_rw_q <= 1'b0;
      mem_wb_rw_q <= 1'b0;
      dec_ex_mr_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_wb_rd_q <= ex_mem_rd_q;
      mem_wb_rw_q <= ex_mem_rw_q;
      ex_mem_rd_q <= dec_ex_rd_q;
      ex_mem_rw_q <= dec_ex_rw_q;
      dec_ex_rd_q <= dec_ex_rd_d;
      dec_ex_rw_q <= dec_ex_rw_d;
      dec_ex_mr_q <= dec_ex_mr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit with MULDIV_CYCLES = 4.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dec_valid;
  logic [4:0] dec_rs, dec_rt, dec_rd;
  logic       dec_uses_rs, dec_uses_rt, dec_regwrite, dec_memread;
  logic       dec_muldiv, dec_mfhilo, ex_branch_taken;
  logic       stall_f, flush_if_dec, flush_dec_ex;
  logic [4:0] dec_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       dec_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite;
  logic       dec_ex_memread, muldiv_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
    .dec_muldiv(dec_muldiv), .dec_mfhilo(dec_mfhilo),
    .ex_branch_taken(ex_branch_taken),
    .stall_f(stall_f), .flush_if_dec(flush_if_dec), .flush_dec_ex(flush_dec_ex),
    .dec_ex_rd(dec_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .dec_ex_regwrite(dec_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_regwrite(mem_wb_regwrite), .dec_ex_memread(dec_ex_memread),
    .muldiv_busy(muldiv_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    dec_valid = 1'b0; dec_rs = '0; dec_rt = '0; dec_rd = '0;
    dec_uses_rs = 1'b0; dec_uses_rt = 1'b0; dec_regwrite = 1'b0;
    dec_memread = 1'b0; dec_muldiv = 1'b0; dec_mfhilo = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt,
                           input logic [4:0] rd, input logic rw, input logic mr,
                           input logic md, input logic mf);
    dec_valid = 1'b1; dec_rs = rs; dec_rt = rt; dec_uses_rs = urs;
    dec_uses_rt = urt; dec_rd = rd; dec_regwrite = rw; dec_memread = mr;
    dec_muldiv = md; dec_mfhilo = mf; ex_branch_taken = 1'b0;
  endtask

  task automatic drain();
    set_nop();
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_nop();
    step();
    step();
    #1;
    n_checks++;
    if ({dec_ex_rd, ex_mem_rd, mem_wb_rd, dec_ex_regwrite, ex_mem_regwrite,
         mem_wb_regwrite, dec_ex_memread, muldiv_busy} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_state: got rd=%0d/%0d/%0d rw=%b%b%b mr=%b busy=%b expected all 0",
               dec_ex_rd, ex_mem_rd, mem_wb_rd, dec_ex_regwrite, ex_mem_regwrite,
               mem_wb_regwrite, dec_ex_memread, muldiv_busy);
    end
    n_checks++;
    if ({stall_f, flush_if_dec, flush_dec_ex} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000", {stall_f, flush_if_dec, flush_dec_ex});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_shadow();
    set_instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_nop();
    n_checks++;
    if ({mem_wb_rd, ex_mem_rd, dec_ex_rd} !== {5'd3, 5'd7, 5'd9}) begin
      n_fail++;
      $display("FAIL shadow_rd: got mem_wb=%0d ex_mem=%0d dec_ex=%0d expected 3 7 9",
               mem_wb_rd, ex_mem_rd, dec_ex_rd);
    end
    n_checks++;
    if ({mem_wb_regwrite, ex_mem_regwrite, dec_ex_regwrite} !== 3'b111) begin
      n_fail++;
      $display("FAIL shadow_rw: got %b expected 111",
               {mem_wb_regwrite, ex_mem_regwrite, dec_ex_regwrite});
    end
    drain();
  endtask

  task automatic test_load_use();
    set_instr(5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_instr(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({stall_f, flush_if_dec, flush_dec_ex} !== 3'b101) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b expected 101", {stall_f, flush_if_dec, flush_dec_ex});
    end
    step();
    n_checks++;
    if ({dec_ex_regwrite, ex_mem_rd, ex_mem_regwrite} !== {1'b0, 5'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL load_use_bubble: got dec_ex_rw=%b ex_mem_rd=%0d ex_mem_rw=%b expected 0 5 1",
               dec_ex_regwrite, ex_mem_rd, ex_mem_regwrite);
    end
    n_checks++;
    if ({stall_f, flush_dec_ex} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_use_one_cycle: got %b expected 00", {stall_f, flush_dec_ex});
    end
    step();
    set_nop();
    n_checks++;
    if ({dec_ex_rd, dec_ex_regwrite} !== {5'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL load_use_accept: got rd=%0d rw=%b expected 8 1", dec_ex_rd, dec_ex_regwrite);
    end
    drain();
  endtask

  task automatic test_load_zero();
    set_instr(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    n_checks++;
    if ({dec_ex_regwrite, dec_ex_memread} !== 2'b01) begin
      n_fail++;
      $display("FAIL load_zero_rw: got rw=%b mr=%b expected 0 1", dec_ex_regwrite, dec_ex_memread);
    end
    set_instr(5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (stall_f !== 1'b0) begin
      n_fail++;
      $display("FAIL load_zero_stall: got %b expected 0", stall_f);
    end
    drain();
  endtask

  task automatic test_branch();
    set_instr(5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_instr(5'd0, 5'd5, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({stall_f, flush_if_dec, flush_dec_ex} !== 3'b011) begin
      n_fail++;
      $display("FAIL branch_vs_load_use: got %b expected 011", {stall_f, flush_if_dec, flush_dec_ex});
    end
    step();
    n_checks++;
    if ({dec_ex_rd, dec_ex_regwrite} !== {5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_squash: got rd=%0d rw=%b expected 0 0", dec_ex_rd, dec_ex_regwrite);
    end
    set_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    step();
    set_nop();
    n_checks++;
    if (muldiv_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_mult_busy: got %b expected 0", muldiv_busy);
    end
    drain();
  endtask

  task automatic test_muldiv();
    set_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall_f !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_issue_stall: got %b expected 0", stall_f);
    end
    step();
    set_instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_checks++;
      if ({muldiv_busy, stall_f, flush_dec_ex} !== 3'b111) begin
        n_fail++;
        $display("FAIL mflo_stall_c%0d: got busy/stall/flush=%b expected 111",
                 c, {muldiv_busy, stall_f, flush_dec_ex});
      end
      step();
    end
    n_checks++;
    if ({muldiv_busy, stall_f, dec_ex_regwrite} !== 3'b000) begin
      n_fail++;
      $display("FAIL mflo_release: got busy/stall/dec_ex_rw=%b expected 000",
               {muldiv_busy, stall_f, dec_ex_regwrite});
    end
    step();
    set_nop();
    n_checks++;
    if ({dec_ex_rd, dec_ex_regwrite} !== {5'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL mflo_accept: got rd=%0d rw=%b expected 2 1", dec_ex_rd, dec_ex_regwrite);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int stalls;
    int busy_cycles;
    stalls = 0;
    busy_cycles = 0;
    set_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_instr(5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!stall_f) break;
      stalls++;
      step();
    end
    n_checks++;
    if (stalls !== 4) begin
      n_fail++;
      $display("FAIL b2b_stall_cycles: got %0d expected 4", stalls);
    end
    step();
    set_nop();
    for (int i = 0; i < 10; i++) begin
      if (!muldiv_busy) break;
      busy_cycles++;
      step();
    end
    n_checks++;
    if (busy_cycles !== 4) begin
      n_fail++;
      $display("FAIL b2b_reload_busy: got %0d expected 4", busy_cycles);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    n_checks++;
    if ({muldiv_busy, dec_ex_rd} !== {1'b1, 5'd6}) begin
      n_fail++;
      $display("FAIL pre_reset_state: got busy=%b rd=%0d expected 1 6", muldiv_busy, dec_ex_rd);
    end
    set_nop();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set_instr(5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if ({dec_ex_rd, ex_mem_rd, mem_wb_rd, dec_ex_regwrite, ex_mem_regwrite,
         mem_wb_regwrite, dec_ex_memread, muldiv_busy, stall_f} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got rd=%0d/%0d/%0d rw=%b%b%b mr=%b busy=%b stall=%b expected all 0",
               dec_ex_rd, ex_mem_rd, mem_wb_rd, dec_ex_regwrite, ex_mem_regwrite,
               mem_wb_regwrite, dec_ex_memread, muldiv_busy, stall_f);
    end
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    set_nop();
    test_reset();
    test_shadow();
    test_load_use();
    test_load_zero();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
